mem_arbiter2: RTL
=================

MEM_ARBITER2 -- requirements
Module: mem_arbiter2

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width; DW/8 byte-mask lanes.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Ports per requester i in {0,1}: m<i>_req  input  1  access request, held until granted.
REQ-007 Ports: m<i>_we  input  1; m<i>_addr  input  AW; m<i>_wdata  input  DW; m<i>_wmask  input  DW/8; these are the access attributes.
REQ-008 Ports: m<i>_gnt  output  1  access accepted this cycle; m<i>_rvalid  output  1  read data valid; m<i>_rdata  output  DW  read data.
REQ-009 Memory-side ports: mem_re  output  1; mem_we  output  1; mem_addr  output  AW; mem_wdata  output  DW; mem_wmask  output  DW/8; mem_rdata  input  DW, valid one cycle after mem_re.
REQ-010 Ports: cnt0  output  16  grants to m0; cnt1  output  16  grants to m1.

Function
REQ-011 The block SHALL issue at most one grant per cycle; m0_gnt and m1_gnt SHALL be mutually exclusive.
REQ-012 m<i>_gnt SHALL be combinational in the same cycle as the m<i>_req it accepts (zero-cycle grant).
REQ-013 With one requester active, that requester SHALL be granted every cycle it requests.
REQ-014 With both requesters active, the block SHALL grant the requester that is not the last winner; the last-winner register (lw) SHALL update only on a grant.
REQ-015 In a granted cycle, the mem_* outputs SHALL carry the winner's attributes: mem_we=we, mem_re=!we, and mem_wmask=wmask for writes, 0 for reads.
REQ-016 With no grant, mem_re, mem_we and mem_wmask SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-017 For a granted read, the block SHALL register a response tag (valid, owner); in the next cycle it SHALL assert m<owner>_rvalid for exactly one cycle with m<owner>_rdata=mem_rdata.
REQ-018 A granted write SHALL produce no rvalid.
REQ-019 m<i>_rdata SHALL be 0 when m<i>_rvalid=0.
REQ-020 Back-to-back operation SHALL be supported: a new grant in the cycle a prior read response returns, giving full throughput with no bubbles.
REQ-021 cnt<i> SHALL increment on each m<i>_gnt and SHALL saturate at 16'hFFFF without wrapping.
REQ-022 A request deasserted before grant SHALL be dropped without side effects.

Reset
REQ-023 On reset, lw SHALL be set to 1 so that m0 wins the first contention.
REQ-024 On reset, the response tag SHALL clear, cnt0 and cnt1 SHALL clear, and the rvalid outputs SHALL be 0 in the following cycle.
REQ-025 While reset is high, gnt outputs and mem_re/mem_we SHALL be forced to 0.
REQ-026 A read granted in the cycle reset is asserted SHALL produce no rvalid.

Structure
REQ-027 Width constants (AW/DW defaults) and the access-mask encodings (byte 0001, half 0011, word 1111) SHALL live in the shared package rv32_pkg.
REQ-028 The two-way round-robin pick SHALL be one sub-module, rr_arb2: inputs req[1:0] and lw; output one-hot gnt[1:0]; combinational.
REQ-029 The tag, lw and counters SHALL reside in mem_arbiter2.

Verification
REQ-030 Reset followed by simultaneous m0/m1 reads of 0x10 and 0x20 SHALL give gnt0 in cycle 1 and gnt1 in cycle 2; rvalid0 with rdata of 0x10 in cycle 2; rvalid1 in cycle 3.
REQ-031 m0 alone requesting for 4 cycles SHALL produce 4 consecutive gnt0 and cnt0=4.
REQ-032 An m1 write (addr 0x8, wdata 0xDEADBEEF, wmask 0011) SHALL give mem_we=1, mem_wmask=0011 in the grant cycle and no rvalid1.
REQ-033 Continuous contention for 6 cycles SHALL strictly alternate grants 0,1,0,1,0,1 with cnt0=cnt1=3.
REQ-034 A read granted with reset asserted the next cycle SHALL produce rvalid0=0 and cnt0=0.
REQ-035 cnt0 preloaded to 0xFFFE by 3 grants SHALL read 0xFFFF and hold.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants and types for the memory arbiter slice.
//   AW_DEF / DW_DEF   default address and data widths
//   MASK_*            byte-lane masks for byte, half-word and word accesses
//   rsp_tag_t         outstanding read response tag (valid, owner)
//   sat_inc16         16-bit increment that sticks at all-ones
package rv32_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req[1:0]  request lines, bit i = requester i
//   lw        index of the requester that won most recently
//   gnt[1:0]  one-hot grant (all zero when nobody requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lw,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Under contention the previous winner yields.
      2'b11:   gnt = lw ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-requester round-robin arbiter in front of a single-port
// memory with one-cycle read latency.
//   clk, reset                          clock, synchronous active-high reset
//   m<i>_req/_we/_addr/_wdata/_wmask    requester i access attributes
//   m<i>_gnt                            access accepted this cycle (combinational)
//   m<i>_rvalid/_rdata                  read response, one cycle after grant
//   mem_re/_we/_addr/_wdata/_wmask      memory command for the winner
//   mem_rdata                           memory read data, valid cycle after mem_re
//   cnt0, cnt1                          saturating grant counters
module mem_arbiter2
  import rv32_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wmask,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,

  output logic            mem_re,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata,

  output logic [15:0]     cnt0,
  output logic [15:0]     cnt1
);

  logic       lw;
  logic [1:0] pick;
  logic [1:0] gnt;
  rsp_tag_t   tag;

  rr_arb2 u_rr_arb2 (
    .req (({m1_req, m0_req})),
    .lw  (lw),
    .gnt (pick)
  );

  // Nothing is accepted while reset is held, so no command reaches memory.
  assign gnt    = reset ? 2'b00 : pick;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (gnt[0]) begin
      mem_we    = m0_we;
      mem_re    = !m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wmask = m0_we ? m0_wmask : '0;
    end else if (gnt[1]) begin
      mem_we    = m1_we;
      mem_re    = !m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wmask = m1_we ? m1_wmask : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lw        <= 1'b1;
      tag.valid <= 1'b0;
      tag.owner <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      tag.valid <= mem_re;
      tag.owner <= gnt[1];
      if (|gnt) lw <= gnt[1];
      if (gnt[0]) cnt0 <= sat_inc16(cnt0);
      if (gnt[1]) cnt1 <= sat_inc16(cnt1);
    end
  end

  // A response due in a reset cycle is discarded along with the tag.
  assign m0_rvalid = tag.valid && !tag.owner && !reset;
  assign m1_rvalid = tag.valid &&  tag.owner && !reset;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
